// File: rtl/keypad_pkg.sv
// keypad_pkg: key map, sweep-result encoding and scan state type shared by the keypad scanner.
package keypad_pkg;

    // Sweep result: bit4 set means no key; otherwise bits 3:0 hold the key code.
    localparam logic [4:0] NO_KEY = 5'h10;

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    typedef enum logic {DRIVE, SAMPLE} scan_state_t;

    function automatic logic [4:0] col_hit(input logic [3:0] rows, input logic [1:0] c);
        col_hit = NO_KEY;
        for (int r = 3; r >= 0; r--)
            if (!rows[r[1:0]]) col_hit = {1'b0, KEYMAP[r[1:0]][c]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a sweep result once it repeats DEBOUNCE_SCANS times in a row
// and strobes press whenever the accepted state becomes a (different) key.
module keypad_debounce import keypad_pkg::*; #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sweep_done,
    input  logic [4:0] result,
    output logic [3:0] code,
    output logic       key_held,
    output logic       press
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_SCANS);

    logic [4:0]    cand, stable;
    logic [CW-1:0] cnt, cnt_nxt;

    assign cnt_nxt  = result != cand ? CW'(1) : cnt == FULL ? FULL : cnt + 1'b1;
    assign code     = stable[3:0];
    assign key_held = !stable[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= NO_KEY;
            cnt    <= '0;
            stable <= NO_KEY;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sweep_done) begin
                cand <= result;
                cnt  <= cnt_nxt;
                if (cnt_nxt == FULL && result != stable) begin
                    stable <= result;
                    press  <= !result[4];
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-sequenced PmodKYPD scanner with sweep debounce and
// valid/ack delivery of accepted presses to the consumer.
module keypad_scan_ctrl import keypad_pkg::*; #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);
    localparam int CW = $clog2(SCAN_CYCLES);
    localparam logic [CW-1:0] LAST_DRIVE = CW'(SCAN_CYCLES - 2);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1, row_s2, code;
    logic [4:0]    acc, sweep;
    logic          sweep_done, press;

    assign col        = ~(4'b0001 << col_idx);
    // First hit of the sweep wins; later columns only fill in while nothing is found yet.
    assign sweep      = acc[4] ? col_hit(row_s2, col_idx) : acc;
    assign sweep_done = state == SAMPLE && col_idx == 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DRIVE;
            cnt     <= '0;
            col_idx <= 2'd0;
            acc     <= NO_KEY;
        end else if (state == DRIVE) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_DRIVE) state <= SAMPLE;
        end else begin
            state   <= DRIVE;
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            acc     <= col_idx == 2'd3 ? NO_KEY : sweep;
        end
    end

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sweep_done(sweep_done),
        .result    (sweep),
        .code      (code),
        .key_held  (key_held),
        .press     (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (press && (!key_valid || key_ack)) key_code <= code;
            if (press) key_valid <= 1'b1;
            else if (key_ack) key_valid <= 1'b0;
            if (press && key_valid && !key_ack) overrun <= 1'b1;
            else if (!press && key_ack && key_valid) overrun <= 1'b0;
        end
    end

endmodule
